alu_sequencer: RTL and testbench

Multi-cycle issue controller that sits in front of the ALU and drives its 3-bit function-select (FS) input. It accepts one decoded RISC-V OP/OP-IMM instruction with operands over a valid/ready handshake, translates opcode/funct3/funct7[5] into an FS code, and sequences the ALU. Shifts are performed as repeated single-bit ALU shift passes with the result fed back as operand A. It returns the result, or an illegal-instruction flag, over a second valid/ready handshake.

---
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle issue controller in front of the ALU. Accepts one decoded
//   RISC-V OP/OP-IMM instruction, maps opcode/funct3/funct7[5] to an ALU
//   function-select code and sequences the ALU. Shifts run as repeated
//   single-bit ALU passes, the result fed back as operand A.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        instruction handshake (ready only in IDLE)
//   opcode, funct3, funct7b5 instruction fields
//   rs1_val, rs2_val, imm    operands (imm sign-extended for I-type)
//   fs, alu_a, alu_b         ALU drive; alu_y is the combinational ALU result
//   out_valid/out_ready      result handshake
//   out_result, out_illegal  result and illegal-instruction flag
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready=1
// EXEC  | single ALU pass for non-shift ops
// SHIFT | one single-bit shift pass per cycle, count down to 1
// DONE  | result presented until out_ready
module alu_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic [WIDTH-1:0] rs1_val,
   input  logic [WIDTH-1:0] rs2_val,
   input  logic [11:0]      imm,
   output logic [2:0]       fs,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] FS_ADD = 3'b000;
   localparam logic [2:0] FS_SUB = 3'b001;
   localparam logic [2:0] FS_SRA = 3'b010;
   localparam logic [2:0] FS_SRL = 3'b011;
   localparam logic [2:0] FS_SLL = 3'b100;
   localparam logic [2:0] FS_AND = 3'b101;
   localparam logic [2:0] FS_OR  = 3'b110;

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

   state_t state_q, state_d;

   logic [2:0]       fs_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic [SHW-1:0]   count_q;
   logic             illegal_q;

   logic             accept;
   logic             is_r;
   logic             is_i;
   logic             dec_illegal;
   logic             dec_shift;
   logic [2:0]       dec_fs;
   logic [WIDTH-1:0] dec_b;
   logic [SHW-1:0]   dec_shamt;

   assign accept      = in_valid & in_ready;
   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_result  = result_q;
   assign out_illegal = illegal_q;

   always_comb begin
      is_r        = (opcode == OPC_OP);
      is_i        = (opcode == OPC_OP_IMM);
      dec_fs      = FS_ADD;
      dec_shift   = 1'b0;
      dec_illegal = 1'b0;
      case (funct3)
         3'b000:  dec_fs = (is_r && funct7b5) ? FS_SUB : FS_ADD;
         3'b001: begin
            dec_fs    = FS_SLL;
            dec_shift = 1'b1;
         end
         3'b101: begin
            dec_fs    = funct7b5 ? FS_SRA : FS_SRL;
            dec_shift = 1'b1;
         end
         3'b111:  dec_fs = FS_AND;
         3'b110:  dec_fs = FS_OR;
         default: dec_illegal = 1'b1;
      endcase
      if (!is_r && !is_i) begin
         dec_illegal = 1'b1;
      end
      dec_b     = is_r ? rs2_val : {{(WIDTH-12){imm[11]}}, imm};
      dec_shamt = is_r ? rs2_val[SHW-1:0] : imm[SHW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fs      = FS_ADD;
      alu_a   = '0;
      alu_b   = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec_illegal) begin
                  state_d = DONE;
               end else if (dec_shift) begin
                  state_d = (dec_shamt == '0) ? DONE : SHIFT;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            fs      = fs_q;
            alu_a   = a_q;
            alu_b   = b_q;
            state_d = DONE;
         end
         SHIFT: begin
            fs    = fs_q;
            alu_a = result_q;
            if (count_q == SHW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_q      <= FS_ADD;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  fs_q      <= dec_fs;
                  a_q       <= rs1_val;
                  b_q       <= dec_b;
                  illegal_q <= dec_illegal;
                  // Shifts seed the feedback register with rs1 so a zero
                  // shift amount can go straight to DONE.
                  if (dec_shift && !dec_illegal) begin
                     result_q <= rs1_val;
                     count_q  <= dec_shamt;
                  end else begin
                     result_q <= '0;
                     count_q  <= '0;
                  end
               end
            end
            EXEC: result_q <= alu_y;
            SHIFT: begin
               result_q <= alu_y;
               count_q  <= count_q - SHW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   localparam logic [6:0] R = 7'b0110011;
   localparam logic [6:0] I = 7'b0010011;
   localparam logic [6:0] L = 7'b0000011;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [11:0] imm;
   logic [2:0]  fs;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
      .fs(fs), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_illegal(out_illegal)
   );

   // Behavioural ALU: shifts move one bit per pass.
   always_comb begin
      case (fs)
         3'b000:  alu_y = alu_a + alu_b;
         3'b001:  alu_y = alu_a - alu_b;
         3'b010:  alu_y = $signed(alu_a) >>> 1;
         3'b011:  alu_y = alu_a >> 1;
         3'b100:  alu_y = alu_a << 1;
         3'b101:  alu_y = alu_a & alu_b;
         3'b110:  alu_y = alu_a | alu_b;
         default: alu_y = 32'h0;
      endcase
   end

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [11:0] im;
      logic [31:0] res;
      logic        ill;
      int          lat;
      logic [2:0]  code;
      int          nz;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input vec_t v, input string name);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      chk({name, "_ready_wait"}, in_ready, 1'b1);
      opcode   = v.opc;
      funct3   = v.f3;
      funct7b5 = v.f7;
      rs1_val  = v.a;
      rs2_val  = v.b;
      imm      = v.im;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run(input vec_t v, input string name);
      int lat;
      int nz;
      int badcode;
      int busy_ready;
      out_ready = 1'b1;
      issue(v, name);
      lat = 1; nz = 0; badcode = 0; busy_ready = 0;
      while (!out_valid && lat < 100) begin
         if (fs != 3'b000) begin
            nz++;
            if (fs != v.code) badcode++;
         end
         if (in_ready) busy_ready++;
         tick();
         lat++;
      end
      chk({name, "_latency"}, lat, v.lat);
      chk({name, "_result"}, out_result, v.res);
      chk({name, "_illegal"}, out_illegal, v.ill);
      chk({name, "_fs_cycles"}, nz, v.nz);
      chk({name, "_fs_code"}, badcode, 0);
      chk({name, "_busy_ready"}, busy_ready, 0);
      tick();
      chk({name, "_idle_ready"}, in_ready, 1'b1);
      chk({name, "_idle_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      int hold_bad;
      int w;
      int seen;
      vec_t v;

      //          opc f3      f7 a             b             im       res            ill lat code    nz
      vecs[0]  = '{R, 3'b000, 0, 32'h5,        32'h7,        12'h000, 32'd12,        0, 2,  3'b000, 0};
      vecs[1]  = '{R, 3'b000, 1, 32'h3,        32'h5,        12'h000, 32'hFFFFFFFE,  0, 2,  3'b001, 1};
      vecs[2]  = '{I, 3'b000, 1, 32'h3,        32'h5,        12'h005, 32'd8,         0, 2,  3'b000, 0};
      vecs[3]  = '{I, 3'b101, 1, 32'h80000000, 32'h0,        12'h404, 32'hF8000000,  0, 5,  3'b010, 4};
      vecs[4]  = '{R, 3'b001, 0, 32'h1234,     32'h20,       12'h000, 32'h1234,      0, 1,  3'b100, 0};
      vecs[5]  = '{R, 3'b010, 0, 32'h1,        32'h2,        12'h000, 32'h0,         1, 1,  3'b000, 0};
      vecs[6]  = '{L, 3'b000, 0, 32'h1,        32'h2,        12'h000, 32'h0,         1, 1,  3'b000, 0};
      vecs[7]  = '{R, 3'b111, 0, 32'hF0F0,     32'hFF00,     12'h000, 32'hF000,      0, 2,  3'b101, 1};
      vecs[8]  = '{R, 3'b110, 0, 32'hF0F0,     32'h0F0F,     12'h000, 32'hFFFF,      0, 2,  3'b110, 1};
      vecs[9]  = '{R, 3'b101, 0, 32'h80000000, 32'h1F,       12'h000, 32'h1,         0, 32, 3'b011, 31};
      vecs[10] = '{I, 3'b001, 0, 32'h1,        32'h0,        12'h003, 32'h8,         0, 4,  3'b100, 3};
      vecs[11] = '{I, 3'b000, 0, 32'h0,        32'h0,        12'hFFF, 32'hFFFFFFFF,  0, 2,  3'b000, 0};
      vecs[12] = '{R, 3'b000, 0, 32'hFFFFFFFF, 32'h1,        12'h000, 32'h0,         0, 2,  3'b000, 0};
      vecs[13] = '{R, 3'b101, 1, 32'h40,       32'h23,       12'h000, 32'h8,         0, 4,  3'b010, 3};
      vecs[14] = '{I, 3'b101, 0, 32'h100,      32'h0,        12'h7E2, 32'h40,        0, 3,  3'b011, 2};
      vecs[15] = '{I, 3'b011, 0, 32'h7,        32'h0,        12'h001, 32'h0,         1, 1,  3'b000, 0};
      vecs[16] = '{R, 3'b100, 0, 32'h7,        32'h9,        12'h000, 32'h0,         1, 1,  3'b000, 0};
      vecs[17] = '{I, 3'b111, 0, 32'h12345678, 32'h0,        12'h800, 32'h12345000,  0, 2,  3'b101, 1};
      vecs[18] = '{I, 3'b110, 0, 32'h1,        32'h0,        12'h0F0, 32'hF1,        0, 2,  3'b110, 1};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1;
      opcode = 7'h0; funct3 = 3'h0; funct7b5 = 1'b0;
      rs1_val = 32'h0; rs2_val = 32'h0; imm = 12'h0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, 32'h0);
      chk("rst_out_illegal", out_illegal, 1'b0);
      chk("rst_fs", fs, 3'b000);
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);

      for (int i = 0; i < 19; i++) begin
         run(vecs[i], $sformatf("v%0d", i));
      end

      // Back-pressure: result held while out_ready is low.
      out_ready = 1'b0;
      issue(vecs[7], "bp");
      w = 0;
      while (!out_valid && w < 20) begin
         tick();
         w++;
      end
      chk("bp_valid_rise", out_valid, 1'b1);
      hold_bad = 0;
      for (int c = 0; c < 3; c++) begin
         if (out_valid !== 1'b1 || out_result !== 32'hF000 ||
             out_illegal !== 1'b0 || in_ready !== 1'b0) hold_bad++;
         tick();
      end
      chk("bp_hold", hold_bad, 0);
      chk("bp_hold_result", out_result, 32'hF000);
      chk("bp_hold_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("bp_release_ready", in_ready, 1'b1);
      chk("bp_release_valid", out_valid, 1'b0);

      // SRAI operand-A feedback stepping.
      issue(vecs[3], "sra_step");
      chk("sra_step1_fs", fs, 3'b010);
      chk("sra_step1_a", alu_a, 32'h80000000);
      chk("sra_step1_b", alu_b, 32'h0);
      tick();
      chk("sra_step2_a", alu_a, 32'hC0000000);
      tick();
      chk("sra_step3_a", alu_a, 32'hE0000000);
      w = 0;
      while (!out_valid && w < 20) begin
         tick();
         w++;
      end
      chk("sra_step_result", out_result, 32'hF8000000);
      tick();

      // Reset during the 3rd cycle of a 10-bit shift.
      v = '{R, 3'b001, 0, 32'h1, 32'hA, 12'h000, 32'h400, 0, 11, 3'b100, 10};
      issue(v, "rst_mid");
      tick();
      tick();
      chk("rst_mid_in_shift", fs, 3'b100);
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", in_ready, 1'b1);
      chk("rst_mid_out_valid", out_valid, 1'b0);
      chk("rst_mid_result", out_result, 32'h0);
      chk("rst_mid_illegal", out_illegal, 1'b0);
      chk("rst_mid_fs", fs, 3'b000);
      chk("rst_mid_alu_a", alu_a, 32'h0);
      chk("rst_mid_alu_b", alu_b, 32'h0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         if (out_valid) seen++;
         tick();
      end
      chk("rst_mid_no_valid", seen, 0);
      run(vecs[0], "post_rst_add");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
